cache_mem_responder: RTL
========================

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request sample to mem_ready pulse (legal 1..255).
REQ-002 SHALL have parameter DEPTH_LINES, default 4096, meaning number of 128-bit lines stored (power of two).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  clock; rst  input  1  async active-low reset.
REQ-004 SHALL have mem_addr  input  32  request byte address from cache controller.
REQ-005 SHALL have mem_data_in  input  128  write line from cache controller.
REQ-006 SHALL have mem_rw  input  1  0=read, 1=write.
REQ-007 SHALL have mem_valid  input  1  request valid, single-cycle pulse.
REQ-008 SHALL have mem_data_out  output  128  read line to cache controller.
REQ-009 SHALL have mem_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have proto_err  output  1  sticky flag, request dropped while busy.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESPOND.
REQ-012 SHALL sample mem_valid in IDLE or RESPOND; on 1, latch line index mem_addr[3+log2(DEPTH_LINES):4], mem_rw, and mem_data_in, then load the counter with LATENCY-1.
REQ-013 SHALL ignore mem_addr[3:0] and address bits above the index, so out-of-range addresses wrap modulo DEPTH_LINES.
REQ-014 SHALL go from IDLE/RESPOND to BUSY on an accepted request when LATENCY>1, or directly to RESPOND when LATENCY==1.
REQ-015 SHALL decrement the counter in BUSY and enter RESPOND when it reaches 0, so mem_ready is high in exactly the LATENCY-th cycle after the sampling edge.
REQ-016 SHALL leave RESPOND for IDLE after one cycle if no new request is sampled.
REQ-017 SHALL commit a write to storage at the edge that enters RESPOND.
REQ-018 SHALL load a read line into mem_data_out at that same edge.
REQ-019 SHALL hold mem_data_out at its last read value outside read responses and on writes.
REQ-020 SHALL accept a request sampled in the RESPOND cycle (back-to-back, as issued by a write-back followed by an allocate), with no idle gap.
REQ-021 SHALL return, for a read following a write to the same line, the written data.
REQ-022 SHALL ignore mem_valid in BUSY and set proto_err, which stays 1 until reset.

Reset
REQ-023 SHALL on rst low asynchronously force state IDLE, mem_ready 0, mem_data_out 0, proto_err 0, counter 0.
REQ-024 SHALL on reset mid-operation drop the pending request with no storage write and no mem_ready pulse.
REQ-025 SHALL not clear storage on reset; storage SHALL be zero at time 0 in simulation.

Configuration
REQ-026 SHALL, when CACHE_MEM_STATS_EN is defined, add outputs rd_count and wr_count (32-bit each), incremented at each read/write commit edge, wrapping at 2^32, and reset to 0.
REQ-027 SHALL, when CACHE_MEM_STATS_EN is undefined, omit those ports and counters entirely.

Structure
REQ-028 SHALL place cache_data_type, mem_req_type, mem_data_type, and the line-offset constant (4) in shared package cache_pkg, used by the controller and this block.
REQ-029 SHALL instantiate one sub-module cache_mem_array, with single-port storage, synchronous write, and asynchronous read of DEPTH_LINES x 128.

Verification (LATENCY=4, DEPTH_LINES=1024)
REQ-030 SHALL cover: write addr 0x0000_0010, data 0x...DEADBEEF, then read 0x0000_0010 -> mem_ready 4 cycles after each valid; read returns 0x...DEADBEEF.
REQ-031 SHALL cover: read 0x0000_4010 after writing 0x0000_0010 -> returns the same line (index wrap, 1024 lines).
REQ-032 SHALL cover: write 0x100 accepted, then read 0x200 pulsed in the write's mem_ready cycle -> second mem_ready exactly 4 cycles later; read data correct; proto_err 0.
REQ-033 SHALL cover: second mem_valid 2 cycles after the first -> ignored; one mem_ready only; proto_err 1 until reset.
REQ-034 SHALL cover: rst low 2 cycles after a write to 0x300 -> no mem_ready; a later read of 0x300 returns the prior contents (0).
REQ-035 SHALL cover, with CACHE_MEM_STATS_EN: 3 reads and 2 writes -> rd_count 3, wr_count 2; both 0 after reset.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: types and constants shared by the cache controller and its
// backing memory responder.
//   cache_data_type : one 128-bit cache line
//   mem_req_type    : request bus payload (address, write line, rw, valid)
//   mem_data_type   : response payload (read line, ready pulse)
//   LINE_OFFSET     : byte-offset bits within a line; the line index starts here
package cache_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned LINE_W      = 128;
   localparam int unsigned LINE_OFFSET = 4;
   localparam int unsigned CNT_W       = 8;

   typedef logic [LINE_W-1:0] cache_data_type;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      cache_data_type    data;
      logic              rw;
      logic              valid;
   } mem_req_type;

   typedef struct packed {
      cache_data_type data;
      logic           ready;
   } mem_data_type;

endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: single-port line storage, DEPTH_LINES x 128 bits.
// Synchronous write, asynchronous (combinational) read; no reset, contents
// survive rst. Storage starts at zero in simulation.
// Ports:
//   clk       : clock
//   wr_en     : write strobe, line written at the rising edge
//   addr      : line index, shared by read and write
//   wr_data   : line to write
//   rd_data_c : line currently stored at addr (combinational)
module cache_mem_array
   import cache_pkg::*;
#(
   parameter  int unsigned DEPTH_LINES = 4096,
   localparam int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] addr,
   input  cache_data_type   wr_data,
   output cache_data_type   rd_data_c
);

   cache_data_type lines [DEPTH_LINES] = '{default: '0};

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lines[addr] <= wr_data;
      end
   end

   // Read port
   assign rd_data_c = lines[addr];

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: fixed-latency backing memory for a cache controller.
// A request sampled in IDLE or RESPOND completes LATENCY cycles later with a
// one-cycle mem_ready pulse; writes commit and reads load mem_data_out at the
// edge entering RESPOND. Requests arriving while BUSY are dropped and set the
// sticky proto_err flag.
// Optional feature: define CACHE_MEM_STATS_EN to add rd_count / wr_count.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   mem_addr      : request byte address (line index = bits above LINE_OFFSET)
//   mem_data_in   : write line
//   mem_rw        : 0 = read, 1 = write
//   mem_valid     : single-cycle request strobe
//   mem_data_out  : last read line (held across writes and idle cycles)
//   mem_ready     : one-cycle completion pulse
//   proto_err     : sticky, request dropped while busy
//   rd_count      : (CACHE_MEM_STATS_EN) read commits, wraps at 2^32
//   wr_count      : (CACHE_MEM_STATS_EN) write commits, wraps at 2^32
module cache_mem_responder
   import cache_pkg::*;
#(
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned DEPTH_LINES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_data_in,
   input  logic              mem_rw,
   input  logic              mem_valid,
   output logic [LINE_W-1:0] mem_data_out,
   output logic              mem_ready,
   output logic              proto_err
`ifdef CACHE_MEM_STATS_EN
   ,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH_LINES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY    = 2'd1;
   localparam logic [1:0] ST_RESPOND = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             rw_q, rw_d;
   cache_data_type   wdata_q, wdata_d;
   logic             err_q, err_d;
   mem_data_type     resp_q, resp_d;

   mem_req_type      req_c;
   logic [IDX_W-1:0] req_idx_c;
   logic             commit_c;
   logic [IDX_W-1:0] sel_idx_c;
   logic             sel_rw_c;
   cache_data_type   sel_data_c;
   cache_data_type   rd_line_c;
   logic             wr_en_c;
   logic             unused_addr;

   // Request bus payload; byte offset and bits above the index are dropped
   assign req_c       = '{addr: mem_addr, data: mem_data_in, rw: mem_rw, valid: mem_valid};
   assign req_idx_c   = req_c.addr[LINE_OFFSET +: IDX_W];
   assign unused_addr = ^req_c.addr;

   // State and request registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         resp_q  <= resp_d;
      end
   end

   // Next state, request capture and commit selection
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rw_d       = rw_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      commit_c   = 1'b0;
      sel_idx_c  = idx_q;
      sel_rw_c   = rw_q;
      sel_data_c = wdata_q;

      case (state_q)
         ST_IDLE, ST_RESPOND: begin
            state_d = ST_IDLE;
            if (req_c.valid) begin
               idx_d   = req_idx_c;
               rw_d    = req_c.rw;
               wdata_d = req_c.data;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY > 1) begin
                  state_d = ST_BUSY;
               end else begin
                  // Single-cycle latency commits the live request directly
                  state_d    = ST_RESPOND;
                  commit_c   = 1'b1;
                  sel_idx_c  = req_idx_c;
                  sel_rw_c   = req_c.rw;
                  sel_data_c = req_c.data;
               end
            end
         end
         ST_BUSY: begin
            if (req_c.valid) begin
               err_d = 1'b1;
            end
            if (cnt_q <= CNT_W'(1)) begin
               state_d  = ST_RESPOND;
               cnt_d    = '0;
               commit_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Response payload and write strobe at the commit edge
   always_comb begin
      resp_d       = resp_q;
      resp_d.ready = commit_c;
      if (commit_c && !sel_rw_c) begin
         resp_d.data = rd_line_c;
      end
      wr_en_c = commit_c & sel_rw_c;
   end

   cache_mem_array #(
      .DEPTH_LINES (DEPTH_LINES)
   ) u_array (
      .clk       (clk),
      .wr_en     (wr_en_c),
      .addr      (sel_idx_c),
      .wr_data   (sel_data_c),
      .rd_data_c (rd_line_c)
   );

   assign mem_data_out = resp_q.data;
   assign mem_ready    = resp_q.ready;
   assign proto_err    = err_q;

`ifdef CACHE_MEM_STATS_EN
   // Commit counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (commit_c) begin
         if (sel_rw_c) begin
            wr_count <= wr_count + 32'd1;
         end else begin
            rd_count <= rd_count + 32'd1;
         end
      end
   end
`endif

endmodule
